vslc_bool_stack: RTL and testbench

//  Parametrised boolean evaluation stack for the VSLC ladder-logic core, replacing the fixed 16-bit stack.

---
 rtl/vslc_pkg.sv | 46 ++++
 rtl/vslc_stack_alu.sv | 107 ++++++++++
 rtl/vslc_bool_stack.sv | 144 ++++++++++++++
 tb/tb_vslc_bool_stack.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/vslc_pkg.sv
// ----------------------------------------------------------------------------
// vslc_pkg
//   Shared types and constants for the VSLC boolean evaluation stack.
//   stack_op_t : 4-bit operation codes driven by the instruction decoder
//   shift_t    : how the parent moves the stack image after an op
//   DEPTH_MIN / DEPTH_MAX : legal range of the stack depth parameter
// ----------------------------------------------------------------------------
package vslc_pkg;

  localparam int STACK_OP_W = 4;
  localparam int DEPTH_MIN  = 3;
  localparam int DEPTH_MAX  = 64;

  typedef enum logic [STACK_OP_W-1:0] {
    OP_NOP   = 4'd0,
    OP_PUSH  = 4'd1,
    OP_POP   = 4'd2,
    OP_DUP   = 4'd3,
    OP_SWAP  = 4'd4,
    OP_OVER  = 4'd5,
    OP_ROT   = 4'd6,
    OP_AND   = 4'd7,
    OP_OR    = 4'd8,
    OP_XOR   = 4'd9,
    OP_NOT   = 4'd10,
    OP_NAND  = 4'd11,
    OP_ANDN  = 4'd12,
    OP_RSV13 = 4'd13,
    OP_RSV14 = 4'd14,
    OP_CLR   = 4'd15
  } stack_op_t;

  // UP    : shift toward the bottom, new bit enters at TOS
  // DOWN1 : plain pop, zero enters at the bottom
  // DOWN2 : two operands consumed, result written at TOS
  // NONE  : depth unchanged, only the top three bits may change
  // CLR   : whole stack zeroed
  typedef enum logic [2:0] {
    SH_NONE  = 3'd0,
    SH_UP    = 3'd1,
    SH_DOWN1 = 3'd2,
    SH_DOWN2 = 3'd3,
    SH_CLR   = 3'd4
  } shift_t;

endpackage

// File: rtl/vslc_stack_alu.sv
// ----------------------------------------------------------------------------
// vslc_stack_alu
//   Combinational op decoder for the boolean stack. From the top three stack
//   bits and the pushed bit it produces the new top three bits, the shift
//   class the parent applies, how many valid entries the op needs, and
//   whether the op code is reserved.
//   op       in  4  operation code (stack_op_t)
//   s0..s2   in  1  current TOS, NOS and third entry
//   din      in  1  bit pushed by PUSH
//   n0..n2   out 1  new top three bits (n0 is the bit entering TOS)
//   shift    out 3  shift class (shift_t)
//   need     out 2  minimum valid entries; fewer means underflow
//   illegal  out 1  reserved op code
// ----------------------------------------------------------------------------
module vslc_stack_alu
  import vslc_pkg::*;
(
  input  logic [STACK_OP_W-1:0] op,
  input  logic                  s0,
  input  logic                  s1,
  input  logic                  s2,
  input  logic                  din,
  output logic                  n0,
  output logic                  n1,
  output logic                  n2,
  output logic [2:0]            shift,
  output logic [1:0]            need,
  output logic                  illegal
);

  always_comb begin
    n0      = s0;
    n1      = s1;
    n2      = s2;
    shift   = SH_NONE;
    need    = 2'd0;
    illegal = 1'b0;
    case (stack_op_t'(op))
      OP_PUSH: begin
        n0    = din;
        shift = SH_UP;
      end
      OP_DUP: begin
        n0    = s0;
        shift = SH_UP;
      end
      OP_OVER: begin
        n0    = s1;
        shift = SH_UP;
        need  = 2'd2;
      end
      OP_POP: begin
        shift = SH_DOWN1;
        need  = 2'd1;
      end
      OP_SWAP: begin
        n0   = s1;
        n1   = s0;
        need = 2'd2;
      end
      // a b c -- b c a : the third entry rotates up to TOS
      OP_ROT: begin
        n0   = s2;
        n1   = s0;
        n2   = s1;
        need = 2'd3;
      end
      OP_NOT: begin
        n0   = ~s0;
        need = 2'd1;
      end
      OP_AND: begin
        n0    = s1 & s0;
        shift = SH_DOWN2;
        need  = 2'd2;
      end
      OP_OR: begin
        n0    = s1 | s0;
        shift = SH_DOWN2;
        need  = 2'd2;
      end
      OP_XOR: begin
        n0    = s1 ^ s0;
        shift = SH_DOWN2;
        need  = 2'd2;
      end
      OP_NAND: begin
        n0    = ~(s1 & s0);
        shift = SH_DOWN2;
        need  = 2'd2;
      end
      OP_ANDN: begin
        n0    = s1 & ~s0;
        shift = SH_DOWN2;
        need  = 2'd2;
      end
      OP_CLR: begin
        shift = SH_CLR;
      end
      OP_RSV13, OP_RSV14: begin
        illegal = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/vslc_bool_stack.sv
// ----------------------------------------------------------------------------
// vslc_bool_stack
//   Parametrised boolean evaluation stack for the VSLC ladder-logic core.
//   Holds a DEPTH-bit shift register (bit 0 = TOS), a valid-entry counter and
//   sticky overflow/underflow/illegal flags. The op decode lives in
//   vslc_stack_alu; this module owns all state.
//   clk, rst    clock; asynchronous active-high reset
//   en          execute op this cycle
//   op, din     operation code and pushed bit
//   clr_flags   clears sticky flags (independent of en; a set wins)
//   stack_o     full stack image, tos/nos its two low bits
//   count       valid entries 0..DEPTH
//   peek_idx    index for peek_o; indices >= DEPTH read 0
//   overflow, underflow, illegal  sticky status flags
// ----------------------------------------------------------------------------
module vslc_bool_stack
  import vslc_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [STACK_OP_W-1:0] op,
  input  logic                  din,
  input  logic                  clr_flags,
  output logic [DEPTH-1:0]      stack_o,
  output logic                  tos,
  output logic                  nos,
  output logic [CNT_W-1:0]      count,
  input  logic [CNT_W-1:0]      peek_idx,
  output logic                  peek_o,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  illegal
);

  generate
    if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
      $error("vslc_bool_stack: DEPTH out of range 3..64");
    end
  endgenerate

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  // 2**CNT_W always exceeds DEPTH, so the padded vector covers every index
  localparam int PEEK_W = 1 << CNT_W;

  logic [DEPTH-1:0] stack_reg, stack_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             ovf_reg, uf_reg, ill_reg;
  logic             set_ovf, set_uf, set_ill;

  logic       alu_n0, alu_n1, alu_n2;
  logic [2:0] alu_shift;
  logic [1:0] alu_need;
  logic       alu_illegal;

  vslc_stack_alu u_alu (
    .op      (op),
    .s0      (stack_reg[0]),
    .s1      (stack_reg[1]),
    .s2      (stack_reg[2]),
    .din     (din),
    .n0      (alu_n0),
    .n1      (alu_n1),
    .n2      (alu_n2),
    .shift   (alu_shift),
    .need    (alu_need),
    .illegal (alu_illegal)
  );

  always_comb begin
    stack_next = stack_reg;
    count_next = count_reg;
    set_ovf    = 1'b0;
    set_uf     = 1'b0;
    set_ill    = 1'b0;
    if (en) begin
      set_ill = alu_illegal;
      set_uf  = (count_reg < CNT_W'(alu_need));
      case (alu_shift)
        SH_UP: begin
          // when full the bottom bit simply falls off the end
          stack_next = {stack_reg[DEPTH-2:0], alu_n0};
          if (count_reg == DEPTH_C) begin
            set_ovf = 1'b1;
          end else begin
            count_next = count_reg + CNT_W'(1);
          end
        end
        SH_DOWN1: begin
          stack_next = {1'b0, stack_reg[DEPTH-1:1]};
          if (!set_uf) begin
            count_next = count_reg - CNT_W'(1);
          end
        end
        SH_DOWN2: begin
          stack_next = {1'b0, stack_reg[DEPTH-1:2], alu_n0};
          if (!set_uf) begin
            count_next = count_reg - CNT_W'(1);
          end
        end
        SH_CLR: begin
          stack_next = '0;
          count_next = '0;
        end
        default: begin
          stack_next[2:0] = {alu_n2, alu_n1, alu_n0};
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stack_reg <= '0;
      count_reg <= '0;
      ovf_reg   <= 1'b0;
      uf_reg    <= 1'b0;
      ill_reg   <= 1'b0;
    end else begin
      stack_reg <= stack_next;
      count_reg <= count_next;
      // a set in the same cycle as clr_flags wins
      ovf_reg   <= set_ovf | (ovf_reg & ~clr_flags);
      uf_reg    <= set_uf  | (uf_reg  & ~clr_flags);
      ill_reg   <= set_ill | (ill_reg & ~clr_flags);
    end
  end

  logic [PEEK_W-1:0] peek_vec;
  assign peek_vec = {{(PEEK_W - DEPTH){1'b0}}, stack_reg};

  assign stack_o   = stack_reg;
  assign tos       = stack_reg[0];
  assign nos       = stack_reg[1];
  assign count     = count_reg;
  assign peek_o    = peek_vec[peek_idx];
  assign overflow  = ovf_reg;
  assign underflow = uf_reg;
  assign illegal   = ill_reg;

endmodule

// File: tb/tb_vslc_bool_stack.sv
module tb_vslc_bool_stack;
  import vslc_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  // DEPTH=4 instance
  logic       en, din, clr_flags;
  logic [3:0] op;
  logic [3:0] stack_o;
  logic       tos, nos, peek_o, overflow, underflow, illegal;
  logic [2:0] count, peek_idx;
  // DEPTH=16 instance
  logic        en16, din16, clr16;
  logic [3:0]  op16;
  logic [15:0] stack16;
  logic        tos16, nos16, peek16, ovf16, uf16, ill16;
  logic [4:0]  count16, peek_idx16;

  vslc_bool_stack #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .op(op), .din(din), .clr_flags(clr_flags),
    .stack_o(stack_o), .tos(tos), .nos(nos), .count(count),
    .peek_idx(peek_idx), .peek_o(peek_o),
    .overflow(overflow), .underflow(underflow), .illegal(illegal)
  );

  vslc_bool_stack #(.DEPTH(16)) dut16 (
    .clk(clk), .rst(rst), .en(en16), .op(op16), .din(din16), .clr_flags(clr16),
    .stack_o(stack16), .tos(tos16), .nos(nos16), .count(count16),
    .peek_idx(peek_idx16), .peek_o(peek16),
    .overflow(ovf16), .underflow(uf16), .illegal(ill16)
  );

  typedef struct {
    logic       en;
    logic [3:0] op;
    logic       din;
    logic       clr;
    logic [3:0] stk;
    logic [2:0] cnt;
    logic [2:0] flg;  // {illegal, underflow, overflow}
  } vec_t;

  vec_t vecs[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic void add(input logic e, input logic [3:0] o, input logic d,
                              input logic c, input logic [3:0] s, input logic [2:0] n,
                              input logic [2:0] f);
    vec_t v;
    v.en = e; v.op = o; v.din = d; v.clr = c; v.stk = s; v.cnt = n; v.flg = f;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_op(input logic e, input logic [3:0] o, input logic d, input logic c);
    en = e; op = o; din = d; clr_flags = c;
    @(posedge clk);
    #1;
    en = 1'b0; op = 4'd0; din = 1'b0; clr_flags = 1'b0;
    $display("op en=%0b code=%0d din=%0b clr=%0b -> stack=%b count=%0d flags=%b%b%b",
             e, o, d, c, stack_o, count, illegal, underflow, overflow);
  endtask

  task automatic do_op16(input logic [3:0] o, input logic d);
    en16 = 1'b1; op16 = o; din16 = d;
    @(posedge clk);
    #1;
    en16 = 1'b0; op16 = 4'd0; din16 = 1'b0;
    $display("op16 code=%0d din=%0b -> count=%0d ovf=%0b", o, d, count16, ovf16);
  endtask

  initial begin
    rst = 1'b1;
    en = 0; op = 0; din = 0; clr_flags = 0; peek_idx = 0;
    en16 = 0; op16 = 0; din16 = 0; clr16 = 0; peek_idx16 = 0;
    #2;
    check("reset_stack", 32'(stack_o), 32'h0);
    check("reset_count", 32'(count), 32'h0);
    check("reset_flags", 32'({illegal, underflow, overflow}), 32'h0);
    #10 rst = 1'b0;

    // reset in the middle of activity clears without a clock edge
    do_op(1, OP_PUSH, 1, 0);
    do_op(1, OP_PUSH, 1, 0);
    check("pre_rst_stack", 32'(stack_o), 32'h3);
    check("pre_rst_count", 32'(count), 32'h2);
    #2 rst = 1'b1;
    #1;
    check("async_rst_stack", 32'(stack_o), 32'h0);
    check("async_rst_count", 32'(count), 32'h0);
    check("async_rst_flags", 32'({illegal, underflow, overflow}), 32'h0);
    #2 rst = 1'b0;

    // en  op        din clr  stack    cnt  {ill,uf,ovf}
    add(1, OP_PUSH,  1, 0, 4'b0001, 3'd1, 3'b000);
    add(1, OP_PUSH,  0, 0, 4'b0010, 3'd2, 3'b000);
    add(1, OP_PUSH,  1, 0, 4'b0101, 3'd3, 3'b000);
    add(1, OP_PUSH,  1, 0, 4'b1011, 3'd4, 3'b000);
    add(1, OP_PUSH,  0, 0, 4'b0110, 3'd4, 3'b001);
    add(1, OP_CLR,   0, 1, 4'b0000, 3'd0, 3'b000);
    add(1, OP_PUSH,  1, 0, 4'b0001, 3'd1, 3'b000);
    add(1, OP_PUSH,  0, 0, 4'b0010, 3'd2, 3'b000);
    add(1, OP_PUSH,  1, 0, 4'b0101, 3'd3, 3'b000);
    add(1, OP_ROT,   0, 0, 4'b0011, 3'd3, 3'b000);
    add(1, OP_NOT,   0, 0, 4'b0010, 3'd3, 3'b000);
    add(1, OP_SWAP,  0, 0, 4'b0001, 3'd3, 3'b000);
    add(1, OP_OVER,  0, 0, 4'b0010, 3'd4, 3'b000);
    add(1, OP_DUP,   0, 0, 4'b0100, 3'd4, 3'b001);
    add(1, OP_AND,   0, 0, 4'b0010, 3'd3, 3'b001);
    add(1, OP_OR,    0, 0, 4'b0001, 3'd2, 3'b001);
    add(1, OP_NAND,  0, 0, 4'b0001, 3'd1, 3'b001);
    add(1, OP_ANDN,  0, 0, 4'b0000, 3'd1, 3'b011);
    add(0, OP_PUSH,  1, 1, 4'b0000, 3'd1, 3'b000);
    add(1, OP_PUSH,  1, 0, 4'b0001, 3'd2, 3'b000);
    add(1, OP_PUSH,  0, 0, 4'b0010, 3'd3, 3'b000);
    add(1, OP_ANDN,  0, 0, 4'b0001, 3'd2, 3'b000);
    add(1, OP_SWAP,  0, 0, 4'b0010, 3'd2, 3'b000);
    add(1, OP_XOR,   0, 0, 4'b0001, 3'd1, 3'b000);
    add(1, OP_POP,   0, 0, 4'b0000, 3'd0, 3'b000);
    add(1, OP_POP,   0, 0, 4'b0000, 3'd0, 3'b010);
    add(1, OP_PUSH,  1, 0, 4'b0001, 3'd1, 3'b010);
    add(1, OP_RSV13, 0, 0, 4'b0001, 3'd1, 3'b110);
    add(1, OP_RSV14, 0, 1, 4'b0001, 3'd1, 3'b100);
    add(1, OP_NOP,   0, 0, 4'b0001, 3'd1, 3'b100);
    add(1, OP_ROT,   0, 0, 4'b0010, 3'd1, 3'b110);
    add(0, OP_CLR,   0, 1, 4'b0010, 3'd1, 3'b000);

    for (int i = 0; i < vecs.size(); i++) begin
      do_op(vecs[i].en, vecs[i].op, vecs[i].din, vecs[i].clr);
      check($sformatf("v%0d_stack", i), 32'(stack_o), 32'(vecs[i].stk));
      check($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].cnt));
      check($sformatf("v%0d_flags", i), 32'({illegal, underflow, overflow}), 32'(vecs[i].flg));
      check($sformatf("v%0d_tos", i), 32'(tos), 32'(vecs[i].stk[0]));
    end

    // two-operand op with only one operand present
    do_op(1, OP_CLR, 0, 1);
    do_op(1, OP_PUSH, 1, 0);
    do_op(1, OP_PUSH, 1, 0);
    do_op(1, OP_XOR, 0, 0);
    check("xor1_tos", 32'(tos), 32'h0);
    check("xor1_count", 32'(count), 32'h1);
    check("xor1_uf", 32'(underflow), 32'h0);
    do_op(1, OP_XOR, 0, 0);
    check("xor2_tos", 32'(tos), 32'h0);
    check("xor2_count", 32'(count), 32'h1);
    check("xor2_uf", 32'(underflow), 32'h1);

    // set beats clear in the same cycle; clear alone then works
    do_op(1, OP_POP, 0, 0);
    check("pop_count", 32'(count), 32'h0);
    do_op(1, OP_POP, 0, 1);
    check("set_wins_uf", 32'(underflow), 32'h1);
    check("set_wins_count", 32'(count), 32'h0);
    do_op(0, OP_NOP, 0, 1);
    check("clr_alone_uf", 32'(underflow), 32'h0);

    // peek port, including indices past the stack
    do_op(1, OP_PUSH, 1, 0);
    do_op(1, OP_PUSH, 0, 0);
    peek_idx = 3'd1; #1;
    check("peek1", 32'(peek_o), 32'h1);
    peek_idx = 3'd0; #1;
    check("peek0", 32'(peek_o), 32'h0);
    peek_idx = 3'd5; #1;
    check("peek5_oob", 32'(peek_o), 32'h0);

    // deep instance: saturation and out-of-range peek
    for (int i = 0; i < 16; i++) do_op16(OP_PUSH, 1);
    check("d16_full_count", 32'(count16), 32'd16);
    check("d16_full_ovf", 32'(ovf16), 32'h0);
    for (int i = 0; i < 4; i++) do_op16(OP_PUSH, 1);
    check("d16_count", 32'(count16), 32'd16);
    check("d16_ovf", 32'(ovf16), 32'h1);
    check("d16_stack", 32'(stack16), 32'hFFFF);
    peek_idx16 = 5'd20; #1;
    check("d16_peek20", 32'(peek16), 32'h0);
    peek_idx16 = 5'd15; #1;
    check("d16_peek15", 32'(peek16), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
